// File: rtl/csr_exec_if.sv
// ---------------------------------------------------------------------------
// csr_exec_if
// Bundle of every non-clock signal around csr_exec_unit: the request
// handshake from the pipeline, the CSR register-file read/write port and the
// response handshake back to writeback.
//
// Modports:
//   master - pipeline / CSR file / writeback side (drives requests, read data,
//            flush and resp_ready; observes everything the unit produces)
//   slave  - csr_exec_unit itself
//
// Signals (direction as seen by the unit):
//   req_valid_i, req_funct3_i[2:0], req_addr_i[ADDR_W], req_rs1_idx_i[4:0],
//   req_rs1_data_i[XLEN], req_rd_idx_i[4:0], flush_i        : in
//   req_ready_o                                             : out
//   csr_raddr_o[ADDR_W], csr_waddr_o[ADDR_W],
//   csr_wdata_o[XLEN], csr_we_o                             : out
//   csr_rdata_i[XLEN]                                       : in
//   resp_valid_o, resp_rd_idx_o[4:0], resp_data_o[XLEN],
//   resp_illegal_o                                          : out
//   resp_ready_i                                            : in
// ---------------------------------------------------------------------------
interface csr_exec_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_funct3_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [4:0]        req_rs1_idx_i;
  logic [XLEN-1:0]   req_rs1_data_i;
  logic [4:0]        req_rd_idx_i;
  logic              flush_i;

  logic [ADDR_W-1:0] csr_raddr_o;
  logic [XLEN-1:0]   csr_rdata_i;
  logic [ADDR_W-1:0] csr_waddr_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic              csr_we_o;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [4:0]        resp_rd_idx_o;
  logic [XLEN-1:0]   resp_data_o;
  logic              resp_illegal_o;

  modport master (
    output req_valid_i, req_funct3_i, req_addr_i, req_rs1_idx_i,
           req_rs1_data_i, req_rd_idx_i, flush_i, csr_rdata_i, resp_ready_i,
    input  req_ready_o, csr_raddr_o, csr_waddr_o, csr_wdata_o, csr_we_o,
           resp_valid_o, resp_rd_idx_o, resp_data_o, resp_illegal_o
  );

  modport slave (
    input  req_valid_i, req_funct3_i, req_addr_i, req_rs1_idx_i,
           req_rs1_data_i, req_rd_idx_i, flush_i, csr_rdata_i, resp_ready_i,
    output req_ready_o, csr_raddr_o, csr_waddr_o, csr_wdata_o, csr_we_o,
           resp_valid_o, resp_rd_idx_o, resp_data_o, resp_illegal_o
  );
endinterface

// File: rtl/csr_exec_unit.sv
// ---------------------------------------------------------------------------
// csr_exec_unit
// Executes Zicsr instructions (CSRRW/RS/RC and their immediate forms) one at
// a time. Reads the CSR file, computes the new value, issues at most one
// write pulse and returns the old value to writeback.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - csr_exec_if.slave (request, CSR file port, response)
//
// Timing: accept at edge N, CSR read during the following cycle (READ),
// csr_we_o during WRITE (N+2), resp_valid_o from N+3 until resp_ready_i.
//
// Optional feature: define CSR_RO_CHECK_EN to reject writes into the
// read-only CSR space (addr[11:10] == 2'b11). Such instructions return
// illegal with data 0 and never reach the CSR file. Pure reads stay legal.
// ---------------------------------------------------------------------------
module csr_exec_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic     clk,
  input  logic     rst,
  csr_exec_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_rs1_idx;
  logic [XLEN-1:0]   r_rs1_data;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_old;
  logic [XLEN-1:0]   r_new;
  logic              r_do_write;
  logic              r_illegal;

  logic [XLEN-1:0]   w_operand;
  logic [XLEN-1:0]   w_new;
  logic              w_legal;
  logic              w_do_write;
  logic              w_illegal;

  // funct3[1:0] selects the operation; funct3[2] only selects the operand.
  function automatic logic [XLEN-1:0] f_new_value(
    input logic [1:0]      op,
    input logic [XLEN-1:0] old,
    input logic [XLEN-1:0] operand
  );
    case (op)
      2'b01:   return operand;
      2'b10:   return old | operand;
      2'b11:   return old & ~operand;
      default: return '0;
    endcase
  endfunction

  // READ-cycle evaluation, using the CSR file's combinational read data.
  always_comb begin
    w_operand  = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;
    w_legal    = (r_funct3[1:0] != 2'b00);
    w_new      = f_new_value(r_funct3[1:0], bus.csr_rdata_i, w_operand);
    // Set/clear with rs1 (or zimm) = 0 is a pure read and must not write,
    // which matters for CSRs with write side effects.
    w_do_write = w_legal && ((r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0));
    w_illegal  = !w_legal;
`ifdef CSR_RO_CHECK_EN
    if (w_do_write && (r_addr[ADDR_W-1:ADDR_W-2] == 2'b11)) begin
      w_do_write = 1'b0;
      w_illegal  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs1_idx  <= '0;
      r_rs1_data <= '0;
      r_rd       <= '0;
      r_old      <= '0;
      r_new      <= '0;
      r_do_write <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A flush in the accept cycle kills the request before capture.
          if (bus.req_valid_i && !bus.flush_i) begin
            r_funct3   <= bus.req_funct3_i;
            r_addr     <= bus.req_addr_i;
            r_rs1_idx  <= bus.req_rs1_idx_i;
            r_rs1_data <= bus.req_rs1_data_i;
            r_rd       <= bus.req_rd_idx_i;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          if (bus.flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_old      <= w_illegal ? '0 : bus.csr_rdata_i;
            r_new      <= w_new;
            r_do_write <= w_do_write;
            r_illegal  <= w_illegal;
            r_state    <= S_WRITE;
          end
        end
        // From WRITE on the instruction is committed; flush is ignored.
        S_WRITE: r_state <= S_RESP;
        S_RESP: begin
          if (bus.resp_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs come straight from captured registers, so response fields stay
  // stable while writeback stalls and all read as 0 after reset.
  assign bus.req_ready_o    = (r_state == S_IDLE);
  assign bus.csr_raddr_o    = r_addr;
  assign bus.csr_waddr_o    = r_addr;
  assign bus.csr_wdata_o    = r_new;
  assign bus.csr_we_o       = (r_state == S_WRITE) && r_do_write;
  assign bus.resp_valid_o   = (r_state == S_RESP);
  assign bus.resp_data_o    = r_old;
  assign bus.resp_rd_idx_o  = r_rd;
  assign bus.resp_illegal_o = r_illegal;

endmodule

// File: tb/tb_csr_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_exec_unit
// Directed bench for csr_exec_unit with a behavioural CSR file (address
// 0xC00 returns a free-running cycle counter) and a response scoreboard.
// Build with or without CSR_RO_CHECK_EN; expectations follow the same macro.
// ---------------------------------------------------------------------------
module tb_csr_exec_unit;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 12;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            ill;
    logic [4:0]      rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] cyc = 64'd0;

  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [XLEN-1:0]   pl_data = '0;
  logic [XLEN-1:0]   csr_mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  csr_exec_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  csr_exec_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 64'd1;

  // CSR file model: preload port for the bench, write port for the DUT.
  always @(posedge clk) begin
    if (pl_en)
      csr_mem[pl_addr] <= pl_data;
    else if (bus.csr_we_o)
      csr_mem[bus.csr_waddr_o] <= bus.csr_wdata_o;
  end

  assign bus.csr_rdata_i = (bus.csr_raddr_o == 12'hC00) ? cyc : csr_mem[bus.csr_raddr_o];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req_ready"},  bus.req_ready_o,    1'b1);
    chk1({tag, "_we"},         bus.csr_we_o,       1'b0);
    chk1({tag, "_resp_valid"}, bus.resp_valid_o,   1'b0);
    chk1({tag, "_illegal"},    bus.resp_illegal_o, 1'b0);
    chk ({tag, "_resp_data"},  bus.resp_data_o,    64'd0);
    chk ({tag, "_rd"},         64'(bus.resp_rd_idx_o), 64'd0);
    chk ({tag, "_raddr"},      64'(bus.csr_raddr_o),   64'd0);
    chk ({tag, "_waddr"},      64'(bus.csr_waddr_o),   64'd0);
    chk ({tag, "_wdata"},      bus.csr_wdata_o,    64'd0);
  endtask

  // One full instruction: drive, check READ/WRITE/RESP cycles, optionally
  // stall writeback for 'hold' cycles, then complete the handshake.
  // flush_wr raises flush_i from WRITE through RESP (must be ignored).
  // cnt=1 means the expected data is the counter value in the READ cycle.
  task automatic do_req(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                        input logic [4:0] idx, input logic [XLEN-1:0] d,
                        input logic [4:0] rd, input logic exp_we,
                        input logic [XLEN-1:0] exp_wd, input logic [XLEN-1:0] exp_data,
                        input logic exp_ill, input int hold, input logic flush_wr,
                        input logic cnt);
    exp_t e;
    @(negedge clk);
    chk1("idle_req_ready", bus.req_ready_o, 1'b1);
    e.data = cnt ? cyc + 64'd1 : exp_data;
    e.ill  = exp_ill;
    e.rd   = rd;
    sb.push_back(e);
    bus.req_valid_i    = 1'b1;
    bus.req_funct3_i   = f3;
    bus.req_addr_i     = a;
    bus.req_rs1_idx_i  = idx;
    bus.req_rs1_data_i = d;
    bus.req_rd_idx_i   = rd;
    @(negedge clk);  // READ
    bus.req_valid_i = 1'b0;
    chk1("read_req_ready", bus.req_ready_o, 1'b0);
    chk ("read_raddr", 64'(bus.csr_raddr_o), 64'(a));
    chk1("read_we", bus.csr_we_o, 1'b0);
    @(negedge clk);  // WRITE
    chk1("write_we", bus.csr_we_o, exp_we);
    if (exp_we) begin
      chk("write_waddr", 64'(bus.csr_waddr_o), 64'(a));
      chk("write_wdata", bus.csr_wdata_o, exp_wd);
    end
    chk1("write_resp_valid", bus.resp_valid_o, 1'b0);
    bus.flush_i = flush_wr;
    @(negedge clk);  // RESP
    chk1("resp_valid", bus.resp_valid_o, 1'b1);
    chk1("resp_we", bus.csr_we_o, 1'b0);
    chk1("resp_req_ready", bus.req_ready_o, 1'b0);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
    end
    chk ("resp_data", bus.resp_data_o, e.data);
    chk1("resp_illegal", bus.resp_illegal_o, e.ill);
    chk ("resp_rd", 64'(bus.resp_rd_idx_o), 64'(e.rd));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk1("hold_valid", bus.resp_valid_o, 1'b1);
      chk ("hold_data", bus.resp_data_o, e.data);
      chk1("hold_illegal", bus.resp_illegal_o, e.ill);
      chk ("hold_rd", 64'(bus.resp_rd_idx_o), 64'(e.rd));
      chk1("hold_req_ready", bus.req_ready_o, 1'b0);
      chk1("hold_we", bus.csr_we_o, 1'b0);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);  // back in IDLE
    bus.resp_ready_i = 1'b0;
    bus.flush_i      = 1'b0;
    chk1("done_resp_valid", bus.resp_valid_o, 1'b0);
    chk1("done_req_ready", bus.req_ready_o, 1'b1);
  endtask

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_funct3_i   = 3'b000;
    bus.req_addr_i     = '0;
    bus.req_rs1_idx_i  = 5'd0;
    bus.req_rs1_data_i = '0;
    bus.req_rd_idx_i   = 5'd0;
    bus.flush_i        = 1'b0;
    bus.resp_ready_i   = 1'b0;

    // Reset, with CSR file preloads done while held in reset.
    preload(12'h005, 64'h1234);
    preload(12'h003, 64'hF0);
    preload(12'h002, 64'hFF);
    preload(12'h006, 64'h3);
    preload(12'h010, 64'h99);
    preload(12'hC00, 64'h0);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_rel");

    // CSRRW
    do_req(3'b001, 12'h005, 5'd1, 64'hDEAD_BEEF, 5'd1, 1'b1, 64'hDEAD_BEEF,
           64'h1234, 1'b0, 0, 1'b0, 1'b0);
    // CSRRS with rs1=0: pure read
    do_req(3'b010, 12'h003, 5'd0, 64'hAA, 5'd2, 1'b0, 64'h0,
           64'hF0, 1'b0, 0, 1'b0, 1'b0);
    // CSRRS with rs1=7
    do_req(3'b010, 12'h003, 5'd7, 64'h0F, 5'd3, 1'b1, 64'hFF,
           64'hF0, 1'b0, 0, 1'b0, 1'b0);
    // CSRRCI zimm=5 (rs1_data must be ignored), writeback stalled 5 cycles
    do_req(3'b111, 12'h002, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b1, 64'hFA,
           64'hFF, 1'b0, 5, 1'b0, 1'b0);
    // CSRRSI with zimm=0: pure read of the value just written
    do_req(3'b110, 12'h002, 5'd0, 64'h1, 5'd5, 1'b0, 64'h0,
           64'hFA, 1'b0, 0, 1'b0, 1'b0);
    // Illegal funct3 100 and 000
    do_req(3'b100, 12'h002, 5'd3, 64'h1, 5'd6, 1'b0, 64'h0,
           64'h0, 1'b1, 0, 1'b0, 1'b0);
    do_req(3'b000, 12'h003, 5'd3, 64'h1, 5'd7, 1'b0, 64'h0,
           64'h0, 1'b1, 0, 1'b0, 1'b0);
    // CSRRWI with flush raised from WRITE onward: still commits
    do_req(3'b101, 12'h006, 5'd31, 64'h0, 5'd8, 1'b1, 64'h1F,
           64'h3, 1'b0, 2, 1'b1, 1'b0);

    // Flush in the accept cycle: request is not taken.
    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.flush_i        = 1'b1;
    bus.req_funct3_i   = 3'b001;
    bus.req_addr_i     = 12'h010;
    bus.req_rs1_idx_i  = 5'd1;
    bus.req_rs1_data_i = 64'h77;
    bus.req_rd_idx_i   = 5'd11;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    chk1("flush_idle_req_ready", bus.req_ready_o, 1'b1);

    // Flush in READ: no write, no response.
    bus.req_valid_i = 1'b1;
    @(negedge clk);  // READ
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b1;
    chk1("flush_read_req_ready", bus.req_ready_o, 1'b0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk1("flush_read_we", bus.csr_we_o, 1'b0);
    chk1("flush_read_resp_valid", bus.resp_valid_o, 1'b0);
    chk1("flush_read_idle", bus.req_ready_o, 1'b1);
    @(negedge clk);
    chk1("flush_read_we2", bus.csr_we_o, 1'b0);
    chk1("flush_read_resp_valid2", bus.resp_valid_o, 1'b0);
    // The aborted CSRRW must have left 0x010 untouched.
    do_req(3'b011, 12'h010, 5'd0, 64'h0, 5'd12, 1'b0, 64'h0,
           64'h99, 1'b0, 0, 1'b0, 1'b0);

    // Read-only CSR space (counter at 0xC00).
`ifdef CSR_RO_CHECK_EN
    do_req(3'b001, 12'hC00, 5'd2, 64'h55, 5'd9, 1'b0, 64'h0,
           64'h0, 1'b1, 0, 1'b0, 1'b0);
`else
    do_req(3'b001, 12'hC00, 5'd2, 64'h55, 5'd9, 1'b1, 64'h55,
           64'h0, 1'b0, 0, 1'b0, 1'b1);
`endif
    do_req(3'b010, 12'hC00, 5'd0, 64'h0, 5'd10, 1'b0, 64'h0,
           64'h0, 1'b0, 0, 1'b0, 1'b1);

    // Synchronous reset while in RESP.
    @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_funct3_i   = 3'b001;
    bus.req_addr_i     = 12'h011;
    bus.req_rs1_idx_i  = 5'd1;
    bus.req_rs1_data_i = 64'h42;
    bus.req_rd_idx_i   = 5'd3;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_resp_valid_before", bus.resp_valid_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_in_resp");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
Name: csr_exec_unit

Overview:
- Executes Zicsr instructions (CSRRW/S/C and immediate forms) on behalf of the pipeline.
- Sits directly upstream of the CSR register file. Drives its read port, captures the old value, computes the new value and issues a single write.
- Returns the old value to writeback through a valid/ready handshake.
- Requests are serialised: one instruction is in flight at a time.

Parameters:
- XLEN, 64, data width of CSR values and rs1 operand.
- ADDR_W, 12, CSR address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid_i  input  1  CSR instruction request valid.
- req_ready_o  output  1  unit can accept a request (high only in IDLE).
- req_funct3_i  input  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- req_addr_i  input  ADDR_W  target CSR address.
- req_rs1_idx_i  input  5  rs1 index; zimm for immediate forms.
- req_rs1_data_i  input  XLEN  rs1 value.
- req_rd_idx_i  input  5  destination register.
- flush_i  input  1  pipeline flush (abort).
- csr_raddr_o  output  ADDR_W  CSR file read address.
- csr_rdata_i  input  XLEN  CSR file combinational read data.
- csr_waddr_o  output  ADDR_W  CSR file write address.
- csr_wdata_o  output  XLEN  CSR file write data.
- csr_we_o  output  1  CSR file write enable (single-cycle pulse).
- resp_valid_o  output  1  result valid.
- resp_ready_i  input  1  writeback accepts result.
- resp_rd_idx_o  output  5  destination register.
- resp_data_o  output  XLEN  old CSR value (0 if illegal).
- resp_illegal_o  output  1  illegal-instruction flag.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset: state IDLE; all captured registers 0. Outputs: req_ready_o=1, csr_we_o=0, resp_valid_o=0, resp_illegal_o=0, resp_data_o=0, resp_rd_idx_o=0, csr_raddr_o=0, csr_waddr_o=0, csr_wdata_o=0.
- IDLE: req_ready_o=1. When req_valid_i=1, capture funct3, addr, rs1_idx, rs1_data and rd, then go to READ. If flush_i=1 in the same cycle, the request is not accepted.
- READ (1 cycle):
  - csr_raddr_o = captured addr; capture csr_rdata_i into old_q.
  - operand = funct3[2] ? zero-extended rs1_idx : rs1_data.
  - new value: RW → operand; RS → old | operand; RC → old & ~operand.
  - do_write = RW/RWI always; RS/RC/RSI/RCI only when rs1_idx != 0.
  - Illegal funct3 (000/100): no write; resp_illegal=1, resp_data=0.
  - Go to WRITE.
- WRITE (1 cycle): csr_we_o = do_write, with csr_waddr_o = addr and csr_wdata_o = new value. Go to RESP.
- RESP: resp_valid_o=1, resp_data_o=old_q, resp_rd_idx_o = captured rd. Hold all response outputs stable until resp_ready_i=1, then go to IDLE. req_ready_o is low here, so there is no back-to-back accept.
- Latency: accept at cycle N; csr_we_o at N+2; resp_valid_o from N+3. Minimum 4 cycles per instruction.
- Flush:
  - flush_i in READ → return to IDLE with no write and no response.
  - flush_i in WRITE or RESP is ignored (the instruction is committed).
- Counter CSRs: the value returned is the CSR file's value during the READ cycle.
- Synchronous reset mid-operation → IDLE next edge. csr_we_o is 0 in the reset cycle's following state; no partial write occurs after reset.

Optional Feature:
- Macro: CSR_RO_CHECK_EN.
- Defined: if do_write=1 and addr[11:10]==2'b11 (read-only CSR space), the write is suppressed, resp_illegal_o=1 and resp_data_o=0.
- Pure reads to read-only CSRs (RS/RC with rs1=0) remain legal.
- Undefined: no read-only check; such writes are issued to the CSR file unchanged.

Test Plan:
- CSRRW addr 0x005, rs1_data 0xDEAD_BEEF, CSR holds 0x1234 → we pulse at N+2 with wdata 0xDEAD_BEEF; resp_data 0x1234 at N+3.
- CSRRS addr 0x003, rs1_idx 0 (CSR 0xF0) → no we pulse; resp_data 0xF0. Repeat with rs1_idx 7, rs1_data 0x0F → wdata 0xFF.
- CSRRCI addr 0x002, zimm 5, CSR 0xFF → wdata 0xFA, resp_data 0xFF; illegal funct3 100 → resp_illegal=1, resp_data 0, no we.
- Hold resp_ready_i low for 5 cycles → resp outputs stable, req_ready_o=0; release → IDLE next cycle, new request accepted.
- flush_i in READ → no we, no resp_valid; synchronous rst asserted in RESP → all outputs at reset values next cycle.
- With CSR_RO_CHECK_EN: CSRRW to 0xC00 → no we, resp_illegal=1. CSRRS 0xC00 rs1=0 → returns cycle count, legal. Without the macro: the CSRRW to 0xC00 issues we.
